btn_press_classifier: RTL and testbench

- Sits directly downstream of the button debouncer and consumes its stable, debounced level.
- Classifies each press as a short press, a long press, or a held press with auto-repeat.
- Emits one-cycle event pulses to the alarm control FSM: set-time, snooze, and fast-increment of hours/minutes.
- One instance per physical button.

---
 rtl/btn_press_classifier_pkg.sv | 29 ++
 rtl/btn_press_classifier_chk.sv | 51 +++++
 rtl/btn_press_classifier_edge_detect.sv | 40 ++++
 rtl/btn_press_classifier.sv | 143 ++++++++++++++
 tb/tb_btn_press_classifier.sv | 137 +++++++++++++
 5 files changed

// File: rtl/btn_press_classifier_pkg.sv
// -----------------------------------------------------------------------------
// btn_press_classifier_pkg
// Shared alarm-clock definitions for the button press classifier:
//   - FSM state encodings (BPC_IDLE / BPC_PRESSED / BPC_LONG_HELD)
//   - default timing constants (system clock rate, long-press and repeat times)
//   - ms_to_cycles(): converts a millisecond duration into clock cycles
// No ports; imported by the classifier, its edge detector and its checker.
// -----------------------------------------------------------------------------
package btn_press_classifier_pkg;

    // System clock frequency in Hz.
    localparam int CLK_HZ        = 32'sd100_000_000;
    // Time the button must stay down before the press counts as long.
    localparam int LONG_PRESS_MS = 32'sd1000;
    // Interval between auto-repeat events while the button stays down.
    localparam int REPEAT_MS     = 32'sd200;

    typedef enum logic [1:0] {
        BPC_IDLE      = 2'd0,
        BPC_PRESSED   = 2'd1,
        BPC_LONG_HELD = 2'd2
    } bpc_state_t;

    // Whole-millisecond duration to clock cycles at CLK_HZ.
    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 32'sd1000) * ms;
    endfunction

endpackage : btn_press_classifier_pkg

// File: rtl/btn_press_classifier_chk.sv
// -----------------------------------------------------------------------------
// btn_press_classifier_chk
// Companion checker for btn_press_classifier. Rejects illegal parameter sets
// at elaboration and watches run-time invariants of the classifier.
// Ports (all inputs):
//   i_clk       clock
//   i_rst       synchronous, active-high reset
//   i_in_press  classifier state is not IDLE
//   i_btn       debounced button level
//   i_fall      falling edge from the edge detector
//   i_short     o_short_press of the classifier
//   i_long      o_long_press of the classifier
//   i_repeat    o_repeat of the classifier
// -----------------------------------------------------------------------------
module btn_press_classifier_chk #(
    parameter int LONG_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input logic i_clk,
    input logic i_rst,
    input logic i_in_press,
    input logic i_btn,
    input logic i_fall,
    input logic i_short,
    input logic i_long,
    input logic i_repeat
);

    localparam longint CNT_SPAN = 64'sd1 <<< CNT_W;

    if (LONG_CYCLES < 2) begin : g_bad_long
        $error("btn_press_classifier: LONG_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("btn_press_classifier: REPEAT_CYCLES must be >= 1");
    end
    if ((CNT_SPAN <= longint'(LONG_CYCLES)) || (CNT_SPAN <= longint'(REPEAT_CYCLES))) begin : g_bad_width
        $error("btn_press_classifier: CNT_W too narrow for LONG_CYCLES/REPEAT_CYCLES");
    end

    // Event pulses never coincide.
    a_pulse_excl: assert property (@(posedge i_clk) disable iff (i_rst)
        $onehot0({i_short, i_long, i_repeat}));

    // While a press is tracked the button was high last cycle, so a low
    // sample must coincide with a detected falling edge.
    a_release_is_fall: assert property (@(posedge i_clk) disable iff (i_rst)
        (i_in_press && !i_btn) |-> i_fall);

endmodule : btn_press_classifier_chk

// File: rtl/btn_press_classifier_edge_detect.sv
// -----------------------------------------------------------------------------
// btn_press_classifier_edge_detect
// One-bit edge detector: keeps the previous sample of i_d in a register and
// flags rising and falling transitions combinationally against it. During
// reset the register is preloaded from the input, so a level that is already
// high when reset is released is not reported as a new rising edge.
// Reusable for the alarm-match and tick-strobe logic.
// Ports:
//   i_clk   in  1  clock
//   i_rst   in  1  synchronous, active-high reset (preloads from i_d)
//   i_d     in  1  sampled level, synchronous to i_clk
//   o_prev  out 1  i_d delayed by one cycle
//   o_rise  out 1  i_d & ~o_prev
//   o_fall  out 1  ~i_d & o_prev
// -----------------------------------------------------------------------------
module btn_press_classifier_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_prev,
    output logic o_rise,
    output logic o_fall
);

    logic d_prev_r;

    // Previous-sample register; reset loads the live input rather than zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            d_prev_r <= i_d;
        end else begin
            d_prev_r <= i_d;
        end
    end

    assign o_prev = d_prev_r;
    assign o_rise = i_d & ~d_prev_r;
    assign o_fall = ~i_d & d_prev_r;

endmodule : btn_press_classifier_edge_detect

// File: rtl/btn_press_classifier.sv
// -----------------------------------------------------------------------------
// btn_press_classifier
// Classifies presses of one debounced button into short press, long press and
// auto-repeat events for the alarm control FSM. One instance per button.
//   - short  : released before LONG_CYCLES consecutive high samples
//   - long   : LONG_CYCLES-th consecutive high sample reached
//   - repeat : every further REPEAT_CYCLES high samples while still held
// All event outputs are registered one-cycle pulses appearing one cycle after
// the deciding input sample.
// Ports:
//   i_clk          in  1  system clock
//   i_rst          in  1  synchronous, active-high reset
//   i_stable_btn   in  1  debounced button level, synchronous to i_clk
//   o_short_press  out 1  short-press pulse
//   o_long_press   out 1  long-press pulse
//   o_repeat       out 1  auto-repeat pulse
//   o_held         out 1  level: a press is in progress
// -----------------------------------------------------------------------------
module btn_press_classifier
    import btn_press_classifier_pkg::*;
#(
    parameter int LONG_CYCLES   = ms_to_cycles(LONG_PRESS_MS),
    parameter int REPEAT_CYCLES = ms_to_cycles(REPEAT_MS),
    parameter int CNT_W         = 27
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_stable_btn,
    output logic o_short_press,
    output logic o_long_press,
    output logic o_repeat,
    output logic o_held
);

    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    bpc_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             short_r;
    logic             long_r;
    logic             repeat_r;
    logic             held_r;
    logic             btn_prev_s;
    logic             rise_s;
    logic             fall_s;

    btn_press_classifier_edge_detect u_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_stable_btn),
        .o_prev (btn_prev_s),
        .o_rise (rise_s),
        .o_fall (fall_s)
    );

    // Press classification FSM with registered event pulses and held level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= BPC_IDLE;
            cnt_r    <= '0;
            short_r  <= 1'b0;
            long_r   <= 1'b0;
            repeat_r <= 1'b0;
            held_r   <= 1'b0;
        end else begin
            short_r  <= 1'b0;
            long_r   <= 1'b0;
            repeat_r <= 1'b0;
            case (state_r)
                BPC_IDLE: begin
                    // held_r lingers one cycle past the release sample, then
                    // follows the next rise (a re-press keeps it high).
                    held_r <= rise_s;
                    if (rise_s) begin
                        state_r <= BPC_PRESSED;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        state_r <= BPC_IDLE;
                        cnt_r   <= '0;
                    end
                end
                BPC_PRESSED: begin
                    held_r <= 1'b1;
                    // Release wins even on the sample that would make it long.
                    if (!i_stable_btn) begin
                        short_r <= 1'b1;
                        state_r <= BPC_IDLE;
                        cnt_r   <= '0;
                    end else if (cnt_r == LONG_LAST) begin
                        long_r  <= 1'b1;
                        state_r <= BPC_LONG_HELD;
                        cnt_r   <= '0;
                    end else begin
                        state_r <= BPC_PRESSED;
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                BPC_LONG_HELD: begin
                    held_r <= 1'b1;
                    if (!i_stable_btn) begin
                        state_r <= BPC_IDLE;
                        cnt_r   <= '0;
                    end else if (cnt_r == REPEAT_LAST) begin
                        repeat_r <= 1'b1;
                        state_r  <= BPC_LONG_HELD;
                        cnt_r    <= '0;
                    end else begin
                        state_r <= BPC_LONG_HELD;
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= BPC_IDLE;
                    cnt_r   <= '0;
                    held_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_short_press = short_r;
    assign o_long_press  = long_r;
    assign o_repeat      = repeat_r;
    assign o_held        = held_r;

    btn_press_classifier_chk #(
        .LONG_CYCLES   (LONG_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_chk (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_in_press (state_r != BPC_IDLE),
        .i_btn      (i_stable_btn),
        .i_fall     (fall_s & btn_prev_s),
        .i_short    (short_r),
        .i_long     (long_r),
        .i_repeat   (repeat_r)
    );

endmodule : btn_press_classifier

// File: tb/tb_btn_press_classifier.sv
// -----------------------------------------------------------------------------
// tb_btn_press_classifier
// Directed bench for btn_press_classifier with LONG_CYCLES=8, REPEAT_CYCLES=4,
// CNT_W=4. Each step drives one input sample, waits for the rising edge and
// compares {short, long, repeat, held} one delta after the edge against a
// hand-computed value.
// -----------------------------------------------------------------------------
module tb_btn_press_classifier;

    localparam logic [3:0] E_NONE  = 4'b0000;
    localparam logic [3:0] E_HELD  = 4'b0001;
    localparam logic [3:0] E_SHORT = 4'b1001;
    localparam logic [3:0] E_LONG  = 4'b0101;
    localparam logic [3:0] E_REP   = 4'b0011;

    logic i_clk;
    logic i_rst;
    logic i_stable_btn;
    logic o_short_press;
    logic o_long_press;
    logic o_repeat;
    logic o_held;

    int n_vec;
    int n_err;

    btn_press_classifier #(
        .LONG_CYCLES   (8),
        .REPEAT_CYCLES (4),
        .CNT_W         (4)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_stable_btn  (i_stable_btn),
        .o_short_press (o_short_press),
        .o_long_press  (o_long_press),
        .o_repeat      (o_repeat),
        .o_held        (o_held)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Drive one sample, clock it in, compare outputs just after the edge.
    task automatic apply(input logic btn, input logic rst, input logic [3:0] exp,
                         input string tag, input int idx);
        logic [3:0] obs;
        i_stable_btn = btn;
        i_rst        = rst;
        @(posedge i_clk);
        #1;
        obs = {o_short_press, o_long_press, o_repeat, o_held};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d]: observed %b expected %b (short,long,rep,held)",
                   tag, idx, obs, exp);
        end
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        i_rst        = 1'b1;
        i_stable_btn = 1'b0;
        #1;

        // Reset state.
        apply(1'b0, 1'b1, E_NONE, "reset", 0);
        apply(1'b0, 1'b1, E_NONE, "reset", 1);
        apply(1'b0, 1'b0, E_NONE, "idle", 0);
        apply(1'b0, 1'b0, E_NONE, "idle", 1);

        // 3-sample press: short pulse after the first low sample, held 4 cycles.
        for (int i = 1; i <= 3; i++) apply(1'b1, 1'b0, E_HELD, "short3", i);
        apply(1'b0, 1'b0, E_SHORT, "short3_rel", 0);
        apply(1'b0, 1'b0, E_NONE,  "short3_after", 0);

        // 7 samples: release on the would-be long sample is still short.
        for (int i = 1; i <= 7; i++) apply(1'b1, 1'b0, E_HELD, "short7", i);
        apply(1'b0, 1'b0, E_SHORT, "short7_rel", 0);
        apply(1'b0, 1'b0, E_NONE,  "short7_after", 0);

        // Exactly 8 samples: long pulse, silent release.
        for (int i = 1; i <= 8; i++)
            apply(1'b1, 1'b0, (i == 8) ? E_LONG : E_HELD, "long8", i);
        apply(1'b0, 1'b0, E_HELD, "long8_rel", 0);
        apply(1'b0, 1'b0, E_NONE, "long8_after", 0);

        // 20 samples: long after 8, repeats after 12, 16, 20, silent release.
        for (int i = 1; i <= 20; i++)
            apply(1'b1, 1'b0,
                  (i == 8) ? E_LONG :
                  ((i == 12) || (i == 16) || (i == 20)) ? E_REP : E_HELD,
                  "hold20", i);
        apply(1'b0, 1'b0, E_HELD, "hold20_rel", 0);
        apply(1'b0, 1'b0, E_NONE, "hold20_after", 0);

        // Button held through reset is not a press.
        apply(1'b1, 1'b1, E_NONE, "rst_held", 0);
        apply(1'b1, 1'b1, E_NONE, "rst_held", 1);
        for (int i = 1; i <= 30; i++) apply(1'b1, 1'b0, E_NONE, "rst_held_hi", i);
        apply(1'b0, 1'b0, E_NONE, "rst_held_rel", 0);
        apply(1'b0, 1'b0, E_NONE, "rst_held_rel", 1);
        for (int i = 1; i <= 3; i++) apply(1'b1, 1'b0, E_HELD, "post_rst_press", i);
        apply(1'b0, 1'b0, E_SHORT, "post_rst_rel", 0);
        apply(1'b0, 1'b0, E_NONE,  "post_rst_after", 0);

        // Reset at high sample 5 discards the press; later release is silent.
        for (int i = 1; i <= 4; i++) apply(1'b1, 1'b0, E_HELD, "mid_rst_press", i);
        apply(1'b1, 1'b1, E_NONE, "mid_rst", 5);
        apply(1'b1, 1'b0, E_NONE, "mid_rst_hi", 6);
        apply(1'b1, 1'b0, E_NONE, "mid_rst_hi", 7);
        apply(1'b0, 1'b0, E_NONE, "mid_rst_rel", 0);
        apply(1'b0, 1'b0, E_NONE, "mid_rst_rel", 1);

        // Two 2-sample presses separated by one low sample: two shorts.
        apply(1'b1, 1'b0, E_HELD,  "dbl_a", 1);
        apply(1'b1, 1'b0, E_HELD,  "dbl_a", 2);
        apply(1'b0, 1'b0, E_SHORT, "dbl_a_rel", 0);
        apply(1'b1, 1'b0, E_HELD,  "dbl_b", 1);
        apply(1'b1, 1'b0, E_HELD,  "dbl_b", 2);
        apply(1'b0, 1'b0, E_SHORT, "dbl_b_rel", 0);

        // Immediate re-press is counted from 1: long exactly at its 8th sample.
        for (int i = 1; i <= 8; i++)
            apply(1'b1, 1'b0, (i == 8) ? E_LONG : E_HELD, "repress_long", i);
        apply(1'b0, 1'b0, E_HELD, "repress_rel", 0);
        apply(1'b0, 1'b0, E_NONE, "repress_after", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_btn_press_classifier
